// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg
//   Shared types and constants for the serial_tx transmitter.
//   - tx_state_t   : frame FSM states
//   - TX_*_LEVEL   : line levels for idle, start and stop bits
//   - min1_clog2() : counter width helper, never returns less than 1
//   The PARITY state is always declared; it is only reachable when
//   SERIAL_TX_PARITY_EN is defined.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = 1'b0;
    localparam logic TX_STOP_LEVEL  = 1'b1;

    function automatic int min1_clog2(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_tx_baud_tick.sv
// baud_tick
//   Bit-time counter. Counts 0..CLKS_PER_BIT-1 and raises tick on the
//   last count, wrapping to 0. While clear is high the counter is held
//   at 0 and tick is suppressed, so the first bit after clear lasts a
//   full CLKS_PER_BIT cycles.
//   Ports:
//     clk   in  clock, rising edge
//     reset in  asynchronous active-high reset
//     clear in  hold counter at 0
//     tick  out one-cycle pulse on the last cycle of a bit time
module baud_tick
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W = min1_clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = !clear && (r_cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// serial_tx
//   Parallel-to-serial transmitter. Accepts a WIDTH-bit word on a
//   valid/ready handshake and sends: start bit, data LSB first,
//   optional even-parity bit, stop bit. Each bit is CLKS_PER_BIT cycles.
//   Optional feature: define SERIAL_TX_PARITY_EN to add the parity bit.
//   Ports:
//     clk      in  clock, rising edge
//     reset    in  asynchronous active-high reset
//     in_valid in  in_data valid
//     in_data  in  [WIDTH] word to send, sampled only on acceptance
//     in_ready out high only in IDLE
//     tx       out serial line (registered), idle high
//     busy     out frame in progress (registered)
//     done     out pulse on the last cycle of the stop bit
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W    = min1_clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    tx_state_t        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [IDX_W-1:0] r_idx,   w_idx_nxt;
    logic             r_tx,    w_tx_nxt;
    logic             r_busy;
    logic             w_accept;
    logic             w_tick;
    logic             w_done;
`ifdef SERIAL_TX_PARITY_EN
    logic             r_par,   w_par_nxt;
`endif

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready;

    // Counter is held clear for the whole of IDLE, which covers the
    // acceptance cycle, so START always gets a full bit time.
    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (in_ready),
        .tick  (w_tick)
    );

    // tx is registered: w_tx_nxt is the level that belongs to the state
    // being entered, so the line changes on the same edge as the state.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_done      = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            IDLE: begin
                w_tx_nxt = TX_IDLE_LEVEL;
                if (w_accept) begin
                    w_state_nxt = START;
                    w_shift_nxt = in_data;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = TX_START_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
                    w_par_nxt   = 1'b0;
`endif
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    w_idx_nxt   = r_idx + IDX_W'(1);
`ifdef SERIAL_TX_PARITY_EN
                    // Parity accumulates each bit as it leaves the line.
                    w_par_nxt   = r_par ^ r_shift[0];
`endif
                    if (r_idx == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_par ^ r_shift[0];
`else
                        w_state_nxt = STOP;
                        w_tx_nxt    = TX_STOP_LEVEL;
`endif
                    end else begin
                        w_tx_nxt = w_shift_nxt[0];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = TX_STOP_LEVEL;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_tx_nxt    = TX_IDLE_LEVEL;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = TX_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= TX_IDLE_LEVEL;
            r_busy  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != IDLE);
`ifdef SERIAL_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = w_done;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx
//   Self-checking bench for serial_tx. Two instances share clk/reset:
//   u_dut (WIDTH=8, CLKS_PER_BIT=4) and u_dut1 (WIDTH=8, CLKS_PER_BIT=1).
//   Expected line levels come from the frame definition: bit j of the
//   frame is start(0), data LSB first, optional ^word, stop(1), each held
//   CLKS_PER_BIT cycles. Honours SERIAL_TX_PARITY_EN.
module tb_serial_tx;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         v0, v1;
    logic [W-1:0] d0, d1;
    logic         rdy0, rdy1, tx0, tx1, bsy0, bsy1, dn0, dn1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(W), .CLKS_PER_BIT(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(v0), .in_data(d0),
        .in_ready(rdy0), .tx(tx0), .busy(bsy0), .done(dn0)
    );

    serial_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1),
        .in_ready(rdy1), .tx(tx1), .busy(bsy1), .done(dn1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    function automatic int cpb(input bit sel);
        return sel ? 1 : 4;
    endfunction

    // Level of frame bit j for word w.
    function automatic logic exp_bit(input logic [W-1:0] w, input int j);
        if (j == 0) return 1'b0;
        if (j <= W) return w[j-1];
        if (PAR != 0 && j == W + 1) return ^w;
        return 1'b1;
    endfunction

    // {tx, busy, done, in_ready}
    function automatic logic [3:0] obs(input bit sel);
        return sel ? {tx1, bsy1, dn1, rdy1} : {tx0, bsy0, dn0, rdy0};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [W-1:0] d);
        if (sel) begin v1 = v; d1 = d; end
        else     begin v0 = v; d0 = d; end
    endtask

    // Called just after a negedge in an IDLE cycle. Offers w, then checks
    // every cycle of the frame and the IDLE cycle that follows it.
    //   disturb: pulse in_valid with 0xFF mid-frame
    //   keep   : hold in_valid and present nxt_w from the done cycle on
    task automatic send(input bit sel, input logic [W-1:0] w, input bit disturb,
                        input logic [W-1:0] nxt_w, input bit keep);
        int         c;
        int         f;
        logic [3:0] o;
        c = cpb(sel);
        f = (W + 2 + PAR) * c;
        drive(sel, 1'b1, w);
        o = obs(sel);
        chk("ready_before_accept", o[0], 1'b1);
        @(posedge clk);
        for (int k = 1; k <= f; k++) begin
            @(negedge clk);
            o = obs(sel);
            chk($sformatf("tx_c%0d_cyc%0d", c, k), o[3], exp_bit(w, (k - 1) / c));
            chk($sformatf("done_c%0d_cyc%0d", c, k), o[1], (k == f));
            if (k == 1 || k == f) begin
                chk($sformatf("busy_cyc%0d", k), o[2], 1'b1);
                chk($sformatf("ready_cyc%0d", k), o[0], 1'b0);
            end
            if (!keep) drive(sel, 1'b0, w);
            if (disturb && k == 3 * c)     drive(sel, 1'b1, 8'hFF);
            if (disturb && k == 3 * c + 1) drive(sel, 1'b0, 8'hFF);
            if (keep && k == f)            drive(sel, 1'b1, nxt_w);
        end
        @(negedge clk);
        o = obs(sel);
        chk("post_tx",    o[3], 1'b1);
        chk("post_busy",  o[2], 1'b0);
        chk("post_ready", o[0], 1'b1);
        chk("post_done",  o[1], 1'b0);
    endtask

    initial begin
        logic [W-1:0] w;
        bit           sel;
        int           gap;

        reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        #1;
        chk("rst_tx",    tx0,  1'b1);
        chk("rst_busy",  bsy0, 1'b0);
        chk("rst_done",  dn0,  1'b0);
        chk("rst_ready", rdy0, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_tx",    tx0,  1'b1);
            chk("idle_busy",  bsy0, 1'b0);
            chk("idle_ready", rdy0, 1'b1);
            chk("idle_done",  dn0,  1'b0);
        end

        // Back to back with in_valid held: 0xA5 then 0x07.
        send(1'b0, 8'hA5, 1'b0, 8'h07, 1'b1);
        send(1'b0, 8'h07, 1'b0, 8'h00, 1'b0);

        // Mid-frame in_data change and in_valid pulse are ignored.
        send(1'b0, 8'hA5, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_second_frame_busy", bsy0, 1'b0);
            chk("no_second_frame_tx",   tx0,  1'b1);
        end

        // One clock per bit.
        send(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);

        // Random words on both instances with random gaps.
        for (int i = 0; i < 8; i++) begin
            sel = i[0];
            w   = W'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            send(sel, w, 1'b0, 8'h00, 1'b0);
        end

        // Reset during data bit 3 (frame bit 4, cycles 17..20).
        w = W'($urandom);
        drive(1'b0, 1'b1, w);
        @(posedge clk);
        repeat (18) @(negedge clk);
        drive(1'b0, 1'b0, w);
        chk("pre_reset_tx_bit3", tx0,  w[3]);
        chk("pre_reset_busy",    bsy0, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_reset_tx",    tx0,  1'b1);
        chk("mid_reset_busy",  bsy0, 1'b0);
        chk("mid_reset_ready", rdy0, 1'b1);
        chk("mid_reset_done",  dn0,  1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_reset_done",  dn0,  1'b0);
            chk("after_reset_ready", rdy0, 1'b1);
            chk("after_reset_tx",    tx0,  1'b1);
        end
        send(1'b0, W'($urandom), 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial transmitter that accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single line as an asynchronous serial frame. The frame is a start bit, the data bits LSB first, an optional even-parity bit, and a stop bit. It is the sending end of the team's serial link: it reads a held word out bit by bit. Load-enabled registers capture words on the receiving side.

## Interface
- WIDTH, 8: data word width in bits, ≥1
- CLKS_PER_BIT, 4: clock cycles per serial bit, ≥1
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data is valid
- in_data  in  WIDTH  word to transmit
- in_ready  out  1  block can accept a word (high only in IDLE)
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse on the last cycle of the stop bit

## Operation
- The interface has one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: state IDLE, tx=1, busy=0, done=0, in_ready=1, internal counters 0. tx and busy are registered, so the async reset forces them immediately.
- The FSM is defined in serial_tx_pkg as tx_state_t:
  - IDLE: tx=1. If in_valid && in_ready at a clock edge, capture in_data into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After bit WIDTH-1, go to PARITY if it is compiled in, otherwise to STOP.
  - PARITY: tx = XOR of the captured word for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. done=1 on the final cycle, then go to IDLE.
- in_data is sampled only at acceptance. Changes to in_data mid-frame have no effect.
- in_valid outside IDLE is ignored. The word is not queued and the sender must hold it until in_ready.
- Width rules:
  - The bit-time counter is max(1,$clog2(CLKS_PER_BIT)) bits and counts 0..CLKS_PER_BIT-1, then wraps to 0 on a bit boundary.
  - The bit index is max(1,$clog2(WIDTH)) bits.
- CLKS_PER_BIT=1 is legal: every state lasts exactly one cycle.
- Reset asserted mid-frame aborts the frame. tx returns to 1 at once, and done is not pulsed.

## Timing
- Acceptance edge T0: tx falls to 0 in the cycle after T0. busy=1 and in_ready=0 from that cycle.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length F = (WIDTH+2)·CLKS_PER_BIT cycles, or (WIDTH+3)·CLKS_PER_BIT with parity.
- done is high during cycle F after T0, which is the last stop-bit cycle.
- The next cycle is IDLE with in_ready=1. The minimum spacing between acceptances is F+1 cycles.
- No combinational path from in_valid to tx. in_ready is decoded from registered state only.

## Configuration
- Macro: SERIAL_TX_PARITY_EN.
- Defined: the PARITY state exists and the frame carries an even-parity bit (^word) between the last data bit and the stop bit.
- Undefined: the PARITY state and parity logic are absent, and DATA goes directly to STOP.
- Both builds have identical port lists.

## Structure
- serial_tx_pkg holds:
  - the typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - the constants TX_IDLE_LEVEL=1'b1, TX_START_LEVEL=1'b0, TX_STOP_LEVEL=1'b1
- One sub-module, baud_tick, is natural: a parameterised CLKS_PER_BIT counter with clk, reset and clear inputs and a one-cycle tick output. Its clear input is driven on acceptance.
- The FSM, shift register, bit index and parity accumulator stay in serial_tx.

## Test plan
- Reset, then idle 10 cycles with in_valid=0 → tx=1, busy=0, in_ready=1, done=0 throughout.
- WIDTH=8, CLKS_PER_BIT=4, no parity, send 0xA5 → tx levels are 0 | 1,0,1,0,0,1,0,1 | 1, each held 4 cycles. done pulses 40 cycles after acceptance, and in_ready=1 in cycle 41.
- Parity build, send 0xA5 then 0x07 back to back with in_valid held → parity bits 0 and 1 respectively. The second word is accepted only in the first cycle in_ready=1 after the first frame's done.
- During the frame, change in_data to 0xFF and pulse in_valid → the transmitted bits still match 0xA5 and no second frame starts.
- CLKS_PER_BIT=1, send 0x01 → tx levels are 0,1,0,0,0,0,0,0,0,1, one cycle each, with done in cycle 10.
- Assert reset during data bit 3 → tx=1 and busy=0 before the next edge. After release, in_ready=1, no done pulse, and a new word is accepted and sent correctly.
